// File: rtl/aes_pkg.sv
// AES-128 shared types, constants and byte-level helpers.
// No logic of its own; used by the SPI front end and the round core.
// No flow control.
package aes_pkg;

  // Round count for AES-128.
  localparam int AES_NR = 10;

  // One state byte per entry. Indexing is [col][row], and [0][0] occupies bits [127:120].
  // A 128-bit FIPS-197 block therefore casts directly into column-major order.
  typedef logic [0:3][0:3][7:0] state_t;
  typedef logic [0:3][7:0]      word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  // Forward S-box. Entry 0 is held in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants. RCON[i] belongs to round i.
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_core.sv
// AES-128 encryption FSM with a one-round-per-cycle datapath and on-the-fly key expansion.
// Latency: 1 capture cycle, 1 whitening cycle and NR round cycles; done stays high while held in DONE.
// No backpressure: a new operand is accepted only from IDLE, and the result is held until load returns.
module aes_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_sync,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         done,
  output logic [127:0] cyphertext
);

  fsm_t       fsm, fsm_nxt;
  logic [3:0] rnd;
  state_t     st, rk;
  state_t     st_nxt, rk_nxt;
  logic       load_prev;
  logic       cap_op, init_op, round_op;
  logic       last_round;

  // SubBytes and ShiftRows combined. Row r rotates left by r columns.
  function automatic state_t sub_shift(input state_t s);
    state_t r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[c][w] = sbox(s[(c + w) & 3][w]);
      end
    end
    return r;
  endfunction

  // Apply MixColumns independently to each of the four columns.
  function automatic state_t mix_cols(input state_t s);
    state_t     m;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c][0];
      a1 = s[c][1];
      a2 = s[c][2];
      a3 = s[c][3];
      m[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return m;
  endfunction

  // Derive the next round key from the current one.
  // The temp word is RotWord, then SubWord, then the Rcon XOR.
  function automatic state_t key_step(input state_t k, input logic [7:0] rc);
    state_t n;
    word_t  t;
    for (int w = 0; w < 4; w++) begin
      t[w] = sbox(k[3][(w + 1) & 3]);
    end
    t[0] = t[0] ^ rc;
    n[0] = k[0] ^ t;
    n[1] = k[1] ^ n[0];
    n[2] = k[2] ^ n[1];
    n[3] = k[3] ^ n[2];
    return n;
  endfunction

  assign last_round = (rnd == 4'(NR));
  assign rk_nxt     = key_step(rk, RCON[rnd]);

  // Round function. The final round skips MixColumns.
  always_comb begin
    st_nxt = sub_shift(st);
    if (!last_round) begin
      st_nxt = mix_cols(st_nxt);
    end
    st_nxt = st_nxt ^ rk_nxt;
  end

  // State register for the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= ST_IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // Next-state logic plus the datapath strobes and the done output.
  always_comb begin
    fsm_nxt  = fsm;
    cap_op   = 1'b0;
    init_op  = 1'b0;
    round_op = 1'b0;
    done     = 1'b0;
    case (fsm)
      ST_IDLE: begin
        if (load_prev && !load_sync) begin
          cap_op  = 1'b1;
          fsm_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        init_op = 1'b1;
        fsm_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        round_op = 1'b1;
        if (last_round) begin
          fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (load_sync) begin
          fsm_nxt = ST_IDLE;
        end
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers.
  // On capture, st holds the plaintext and rk holds the cipher key.
  // The sck-domain register is quiet at that point because load is already low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnd        <= 4'd0;
      st         <= '0;
      rk         <= '0;
      cyphertext <= '0;
      load_prev  <= 1'b0;
    end else begin
      load_prev <= load_sync;
      if (cap_op) begin
        st <= plaintext;
        rk <= key;
      end
      if (init_op) begin
        st  <= st ^ rk;
        rnd <= 4'd1;
      end
      if (round_op) begin
        st  <= st_nxt;
        rk  <= rk_nxt;
        rnd <= rnd + 4'd1;
        if (last_round) begin
          cyphertext <= st_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/aes_spi.sv
// SPI-loaded AES-128 peripheral: sck-domain operand and result shifters, load synchroniser, round core.
// Latency: done rises about 14 clk cycles after load falls, and never later than 16.
// No backpressure: the host polls done and then clocks out 128 bits; edges beyond 128 return 0.
module aes_spi
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  output logic sdo,
  input  logic load,
  output logic done
);

  logic [255:0] shreg;
  logic [7:0]   rise_cnt;
  logic [7:0]   fall_cnt;
  logic         load_s1, load_sync;
  logic [127:0] cyphertext;

  // Operand shifter.
  // While load is high it also rearms the result read pointer, so each new result is read from bit 127.
  // Once 128 bits have been read, the read pointer saturates.
  always_ff @(posedge sck) begin
    if (load) begin
      shreg    <= {shreg[254:0], sdi};
      rise_cnt <= 8'd0;
    end else if (done && !rise_cnt[7]) begin
      rise_cnt <= rise_cnt + 8'd1;
    end
  end

  // The read pointer moves to sdo on the falling edge, so sdo stays stable while sck is high.
  always_ff @(negedge sck) begin
    if (load) begin
      fall_cnt <= 8'd0;
    end else begin
      fall_cnt <= rise_cnt;
    end
  end

  // Two-flop synchroniser that brings load into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_s1   <= 1'b0;
      load_sync <= 1'b0;
    end else begin
      load_s1   <= load;
      load_sync <= load_s1;
    end
  end

  aes_core #(
    .NR(NR)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load_sync (load_sync),
    .plaintext (shreg[255:128]),
    .key       (shreg[127:0]),
    .done      (done),
    .cyphertext(cyphertext)
  );

  // sdo source: the cyphertext bit MSB first while done is high, otherwise the operand register MSB.
  always_comb begin
    sdo = shreg[255];
    if (done) begin
      sdo = fall_cnt[7] ? 1'b0 : cyphertext[~fall_cnt[6:0]];
    end
  end

endmodule

// File: tb/tb_aes_spi.sv
module tb_aes_spi;

  logic clk = 1'b0;
  logic reset, sck, sdi, sdo, load, done;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic [127:0] ct;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes_spi dut (
    .clk  (clk),
    .reset(reset),
    .sck  (sck),
    .sdi  (sdi),
    .sdo  (sdo),
    .load (load),
    .done (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [127:0] pt, input logic [127:0] k);
    logic [255:0] d;
    d = {pt, k};
    load = 1'b1;
    #3;
    for (int i = 255; i >= 0; i--) begin
      sdi = d[i];
      #4 sck = 1'b1;
      #7 sck = 1'b0;
      #4;
    end
    #3 load = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic read_out(output logic [127:0] data);
    for (int i = 127; i >= 0; i--) begin
      data[i] = sdo;
      sck = 1'b1;
      #7 sck = 1'b0;
      #7;
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    sck   = 1'b0;
    sdi   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 128'(done), 128'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // FIPS-197 C.1 vector.
    shift_in(C1_PT, C1_KEY);
    wait_done(lat);
    chk("c1_latency_le16", (lat <= 16) ? 128'd1 : 128'd0, 128'd1);
    read_out(ct);
    chk("c1_cyphertext", ct, C1_CT);
    chk("c1_sdo_after_128", 128'(sdo), 128'd0);
    sck = 1'b1;
    #7 sck = 1'b0;
    #7;
    chk("c1_sdo_after_129", 128'(sdo), 128'd0);

    // Back to back with the Appendix B vector: raising load must clear done.
    load = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_done_drop", 128'(done), 128'd0);
    shift_in(B_PT, B_KEY);
    wait_done(lat);
    chk("b_latency_le16", (lat <= 16) ? 128'd1 : 128'd0, 128'd1);
    read_out(ct);
    chk("b_cyphertext", ct, B_CT);

    // All-zero key and plaintext.
    load = 1'b1;
    repeat (4) @(posedge clk);
    shift_in(128'd0, 128'd0);
    wait_done(lat);
    chk("zero_latency_le16", (lat <= 16) ? 128'd1 : 128'd0, 128'd1);
    read_out(ct);
    chk("zero_cyphertext", ct, Z_CT);

    // Reset 5 clk after load falls aborts the run.
    shift_in(C1_PT, C1_KEY);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_done_low", 128'(done), 128'd0);

    // Reload C.1, then hold for 100 clk before reading out.
    shift_in(C1_PT, C1_KEY);
    wait_done(lat);
    chk("reload_latency_le16", (lat <= 16) ? 128'd1 : 128'd0, 128'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_done_high", 128'(done), 128'd1);
    chk("hold_first_sdo", 128'(sdo), 128'd0);
    read_out(ct);
    chk("hold_cyphertext", ct, C1_CT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
